apb_fsm_controller: RTL

- Sequences APB transfers for the AHB-to-APB bridge.
- Consumes the slave interface's decoded request (valid, tempselx) and its pipelined address/data/write registers.
- Drives the APB master signals and the AHB hreadyout stall.
- Handles single reads, single writes and back-to-back pipelined writes with a registered Moore FSM.

---
 rtl/apb_fsm_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_fsm_controller.sv
// APB transfer sequencer for the AHB-to-APB bridge: registered Moore FSM driving APB strobes and hreadyout.
// Optional macro PREADY_WAIT_EN adds a pready input that stretches access phases.
module apb_fsm_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwritereg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic [2:0]        tempselx,
`ifdef PREADY_WAIT_EN
  input  logic              pready,
`endif
  output logic              pwrite,
  output logic              penable,
  output logic [2:0]        pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t             state_reg, state_next;
  logic [2:0]         sel1_reg, sel2_reg;
  logic               pwrite_next, penable_next, hreadyout_next;
  logic [2:0]         pselx_next;
  logic [ADDR_W-1:0]  paddr_next;
  logic [DATA_W-1:0]  pwdata_next;
  logic               access_ready;
  logic               in_access;
  logic               hold_access;
  logic               from_pipe;

  // Illegal (non one-hot) selects collapse to zero so the transfer becomes a no-op.
  function automatic logic [2:0] legal_sel(input logic [2:0] s);
    if (s == 3'b001 || s == 3'b010 || s == 3'b100)
      return s;
    return 3'b000;
  endfunction

`ifdef PREADY_WAIT_EN
  assign access_ready = pready;
`else
  assign access_ready = 1'b1;
`endif

  assign in_access   = (state_reg == ST_RENABLE) || (state_reg == ST_WENABLE) ||
                       (state_reg == ST_WENABLEP);
  assign hold_access = in_access && !access_ready;
  // After a pipelined write the queued request sits two address stages back.
  assign from_pipe   = (state_reg == ST_WENABLEP);

  always_comb begin
    state_next = state_reg;
    if (!hold_access) begin
      case (state_reg)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          if (valid && hwrite)
            state_next = ST_WWAIT;
          else if (valid)
            state_next = ST_READ;
          else
            state_next = ST_IDLE;
        end
        ST_WWAIT:    state_next = valid ? ST_WRITEP : ST_WRITE;
        ST_READ:     state_next = ST_RENABLE;
        ST_WRITE:    state_next = valid ? ST_WENABLEP : ST_WENABLE;
        ST_WRITEP:   state_next = ST_WENABLEP;
        ST_WENABLEP: begin
          if (!hwritereg)
            state_next = ST_READ;
          else if (valid)
            state_next = ST_WRITEP;
          else
            state_next = ST_WRITE;
        end
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pwrite_next    = pwrite;
    penable_next   = penable;
    pselx_next     = pselx;
    paddr_next     = paddr;
    pwdata_next    = pwdata;
    hreadyout_next = hreadyout;
    if (hold_access) begin
      hreadyout_next = 1'b0;
    end else begin
      case (state_next)
        ST_READ: begin
          paddr_next     = from_pipe ? haddr2 : haddr;
          pselx_next     = legal_sel(from_pipe ? sel2_reg : tempselx);
          pwrite_next    = 1'b0;
          penable_next   = 1'b0;
          hreadyout_next = 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          paddr_next     = from_pipe ? haddr2 : haddr1;
          pselx_next     = legal_sel(from_pipe ? sel2_reg : sel1_reg);
          pwdata_next    = from_pipe ? hwdata1 : hwdata;
          pwrite_next    = 1'b1;
          penable_next   = 1'b0;
          hreadyout_next = 1'b0;
        end
        ST_RENABLE, ST_WENABLE: begin
          penable_next   = |pselx;
          hreadyout_next = 1'b1;
        end
        ST_WENABLEP: begin
          penable_next   = |pselx;
          hreadyout_next = 1'b0;
        end
        default: begin
          pselx_next     = 3'b000;
          penable_next   = 1'b0;
          hreadyout_next = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg <= ST_IDLE;
      sel1_reg  <= 3'b000;
      sel2_reg  <= 3'b000;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= 3'b000;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state_reg <= state_next;
      sel1_reg  <= tempselx;
      sel2_reg  <= sel1_reg;
      pwrite    <= pwrite_next;
      penable   <= penable_next;
      pselx     <= pselx_next;
      paddr     <= paddr_next;
      pwdata    <= pwdata_next;
      hreadyout <= hreadyout_next;
    end
  end

endmodule
